// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction-fetch / load-store memory arbiter.
package mem_arb_pkg;

    localparam int unsigned STARVE_LIMIT_DEFAULT = 3;
    localparam logic [3:0]  FETCH_BYTE_EN        = 4'b1111;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store,
// with a single outstanding access and a starvation guard for fetch.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_wr_en_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    input  logic [3:0]  ls_byte_en_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_req_o,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_byte_en_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o
);

    localparam int unsigned   SW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_W = SW'(STARVE_LIMIT);

    arb_state_e    r_state;
    arb_owner_e    r_owner;
    logic          r_lock;
    arb_owner_e    r_lockOwner;
    logic [SW-1:0] r_streak;

    arb_state_e    w_stateNext;
    arb_owner_e    w_ownerNext;
    logic          w_lockNext;
    arb_owner_e    w_lockOwnerNext;
    logic [SW-1:0] w_streakNext;

    arb_owner_e    w_sel;
    logic          w_issueOk;
    logic          w_memReq;
    logic          w_grant;
    logic          w_respValid;
    logic          w_respWindow;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_owner     <= OWN_IF;
            r_lock      <= 1'b0;
            r_lockOwner <= OWN_IF;
            r_streak    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_lock      <= w_lockNext;
            r_lockOwner <= w_lockOwnerNext;
            r_streak    <= w_streakNext;
        end
    end

    always_comb begin
        w_grant         = w_memReq && mem_gnt_i;
        w_stateNext     = r_state;
        w_ownerNext     = r_owner;
        if (w_grant) begin
            w_stateNext = WAIT_RESP;
            w_ownerNext = w_sel;
        end else if ((r_state == WAIT_RESP) && mem_rvalid_i) begin
            w_stateNext = IDLE;
        end
        // A request left hanging by the memory keeps its owner until accepted.
        w_lockNext      = w_memReq && !mem_gnt_i;
        w_lockOwnerNext = w_sel;
        if ((w_grant && (w_sel == OWN_IF)) || !if_req_i) begin
            w_streakNext = '0;
        end else if (w_grant && (w_sel == OWN_LS) && (r_streak != LIMIT_W)) begin
            w_streakNext = r_streak + SW'(1);
        end else begin
            w_streakNext = r_streak;
        end
    end

    always_comb begin
        w_issueOk = (r_state == IDLE) || mem_rvalid_i;
        if (r_lock) begin
            w_sel = r_lockOwner;
        end else if (if_req_i && ls_req_i) begin
            w_sel = (r_streak == LIMIT_W) ? OWN_IF : OWN_LS;
        end else if (ls_req_i) begin
            w_sel = OWN_LS;
        end else begin
            w_sel = OWN_IF;
        end
        w_memReq     = !rst_i && w_issueOk && (r_lock || if_req_i || ls_req_i);
        w_respWindow = !rst_i && (r_state == WAIT_RESP);
        w_respValid  = w_respWindow && mem_rvalid_i;

        mem_req_o     = w_memReq;
        mem_wr_en_o   = 1'b0;
        mem_addr_o    = '0;
        mem_wdata_o   = '0;
        mem_byte_en_o = '0;
        if (w_memReq) begin
            if (w_sel == OWN_IF) begin
                mem_addr_o    = if_addr_i;
                mem_byte_en_o = FETCH_BYTE_EN;
            end else begin
                mem_wr_en_o   = ls_wr_en_i;
                mem_addr_o    = ls_addr_i;
                mem_wdata_o   = ls_wdata_i;
                mem_byte_en_o = ls_byte_en_i;
            end
        end

        if_gnt_o    = w_memReq && mem_gnt_i && (w_sel == OWN_IF);
        ls_gnt_o    = w_memReq && mem_gnt_i && (w_sel == OWN_LS);
        if_rvalid_o = w_respValid && (r_owner == OWN_IF);
        ls_rvalid_o = w_respValid && (r_owner == OWN_LS);
        if_rdata_o  = (w_respWindow && (r_owner == OWN_IF)) ? mem_rdata_i : '0;
        ls_rdata_o  = (w_respWindow && (r_owner == OWN_LS)) ? mem_rdata_i : '0;

        stall_o = !rst_i && ((if_req_i && !if_gnt_o) || (ls_req_i && !ls_gnt_o) ||
                             ((r_state == WAIT_RESP) && !mem_rvalid_i));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// multi-cycle corner sequences, and a randomized run against a reference model.
module tb_mem_arbiter;

    localparam int LIMIT = 3;

    typedef struct {
        logic        ifReq;
        logic [31:0] ifAddr;
        logic        lsReq;
        logic        lsWr;
        logic [31:0] lsAddr;
        logic [31:0] lsWdata;
        logic [3:0]  lsBe;
        logic        memGnt;
        logic        memRvalid;
        logic [31:0] memRdata;
    } stim_t;

    typedef struct {
        logic        ifGnt;
        logic        lsGnt;
        logic        ifRv;
        logic        lsRv;
        logic        memReq;
        logic        stall;
        logic        memWr;
        logic [31:0] memAddr;
        logic [3:0]  memBe;
        logic [31:0] memWdata;
        logic        chkIfData;
        logic        chkLsData;
        logic [31:0] rdata;
    } expect_t;

    typedef struct {
        stim_t   stim;
        expect_t exp;
    } vector_t;

    typedef struct {
        bit isFetch;
        bit isWrite;
    } access_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        ls_req_i = 1'b0;
    logic        ls_wr_en_i = 1'b0;
    logic [31:0] ls_addr_i = '0;
    logic [31:0] ls_wdata_i = '0;
    logic [3:0]  ls_byte_en_i = '0;
    logic        ls_gnt_o;
    logic        ls_rvalid_o;
    logic [31:0] ls_rdata_o;
    logic        mem_req_o;
    logic        mem_wr_en_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_byte_en_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        stall_o;

    int errorCount = 0;
    int checkCount = 0;

    mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .ls_req_i(ls_req_i), .ls_wr_en_i(ls_wr_en_i), .ls_addr_i(ls_addr_i),
        .ls_wdata_i(ls_wdata_i), .ls_byte_en_i(ls_byte_en_i), .ls_gnt_o(ls_gnt_o),
        .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
        .mem_req_o(mem_req_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic stim_t mkStim(logic ifReq, logic [31:0] ifAddr, logic lsReq, logic lsWr,
                                     logic [31:0] lsAddr, logic [31:0] lsWdata, logic [3:0] lsBe,
                                     logic memGnt, logic memRvalid, logic [31:0] memRdata);
        stim_t s;
        s.ifReq = ifReq;   s.ifAddr = ifAddr;   s.lsReq = lsReq;       s.lsWr = lsWr;
        s.lsAddr = lsAddr; s.lsWdata = lsWdata; s.lsBe = lsBe;         s.memGnt = memGnt;
        s.memRvalid = memRvalid;                s.memRdata = memRdata;
        return s;
    endfunction

    function automatic expect_t mkExp(logic ifGnt, logic lsGnt, logic ifRv, logic lsRv,
                                      logic memReq, logic stall, logic memWr, logic [31:0] memAddr,
                                      logic [3:0] memBe, logic [31:0] memWdata,
                                      logic chkIfData, logic chkLsData, logic [31:0] rdata);
        expect_t e;
        e.ifGnt = ifGnt;     e.lsGnt = lsGnt;   e.ifRv = ifRv;         e.lsRv = lsRv;
        e.memReq = memReq;   e.stall = stall;   e.memWr = memWr;       e.memAddr = memAddr;
        e.memBe = memBe;     e.memWdata = memWdata;
        e.chkIfData = chkIfData;                e.chkLsData = chkLsData;
        e.rdata = rdata;
        return e;
    endfunction

    function automatic stim_t quietStim();
        return mkStim(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic expect_t zeroExp();
        return mkExp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic applyStimulus(input stim_t s);
        if_req_i     = s.ifReq;
        if_addr_i    = s.ifAddr;
        ls_req_i     = s.lsReq;
        ls_wr_en_i   = s.lsWr;
        ls_addr_i    = s.lsAddr;
        ls_wdata_i   = s.lsWdata;
        ls_byte_en_i = s.lsBe;
        mem_gnt_i    = s.memGnt;
        mem_rvalid_i = s.memRvalid;
        mem_rdata_i  = s.memRdata;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Field checks apply only where the value is meaningful for the cycle.
    task automatic checkCycle(input string name, input expect_t e);
        checkOutput({name, ".ctrl"},
                    128'({if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, mem_req_o, stall_o}),
                    128'({e.ifGnt, e.lsGnt, e.ifRv, e.lsRv, e.memReq, e.stall}));
        if (e.memReq)
            checkOutput({name, ".memFields"},
                        128'({mem_wr_en_o, mem_addr_o, mem_byte_en_o, mem_wdata_o}),
                        128'({e.memWr, e.memAddr, e.memBe, e.memWdata}));
        if (e.chkIfData)
            checkOutput({name, ".ifRdata"}, 128'(if_rdata_o), 128'(e.rdata));
        if (e.chkLsData)
            checkOutput({name, ".lsRdata"}, 128'(ls_rdata_o), 128'(e.rdata));
    endtask

    task automatic runVector(input string name, input stim_t s, input expect_t e);
        applyStimulus(s);
        #1;
        checkCycle(name, e);
        @(negedge clk_i);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        runVector("resetHeld", quietStim(), zeroExp());
        runVector("resetHeld", quietStim(), zeroExp());
        rst_i = 1'b0;
        runVector("afterReset", quietStim(), zeroExp());
    endtask

    task automatic runTable();
        vector_t vecs[9];
        vecs[0].stim = mkStim(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[0].exp  = mkExp(1, 0, 0, 0, 1, 0, 0, 32'h100, 4'hF, 0, 0, 0, 0);
        vecs[1].stim = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00500093);
        vecs[1].exp  = mkExp(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00500093);
        vecs[2].stim = mkStim(1, 32'h104, 1, 1, 32'h2000, 32'hDEADBEEF, 4'hF, 1, 0, 0);
        vecs[2].exp  = mkExp(0, 1, 0, 0, 1, 1, 1, 32'h2000, 4'hF, 32'hDEADBEEF, 0, 0, 0);
        vecs[3].stim = mkStim(1, 32'h104, 0, 0, 0, 0, 0, 1, 1, 32'h0);
        vecs[3].exp  = mkExp(1, 0, 0, 1, 1, 0, 0, 32'h104, 4'hF, 0, 0, 0, 0);
        vecs[4].stim = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11223344);
        vecs[4].exp  = mkExp(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h11223344);
        vecs[5].stim = mkStim(0, 0, 1, 0, 32'h3001, 0, 4'b0001, 1, 0, 0);
        vecs[5].exp  = mkExp(0, 1, 0, 0, 1, 0, 0, 32'h3001, 4'b0001, 0, 0, 0, 0);
        vecs[6].stim = quietStim();
        vecs[6].exp  = mkExp(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[7].stim = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A58081);
        vecs[7].exp  = mkExp(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A58081);
        vecs[8].stim = mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h12345678);
        vecs[8].exp  = zeroExp();
        for (int i = 0; i < 9; i++)
            runVector($sformatf("table[%0d]", i), vecs[i].stim, vecs[i].exp);
    endtask

    task automatic runStarvation();
        stim_t s;
        doReset();
        s = mkStim(1, 32'h200, 1, 0, 32'h5000, 0, 4'hF, 1, 0, 0);
        runVector("starve0", s, mkExp(0, 1, 0, 0, 1, 1, 0, 32'h5000, 4'hF, 0, 0, 0, 0));
        s.memRvalid = 1; s.memRdata = 32'hC0DE0001;
        runVector("starve1", s, mkExp(0, 1, 0, 1, 1, 1, 0, 32'h5000, 4'hF, 0, 0, 1, 32'hC0DE0001));
        s.memRdata = 32'hC0DE0002;
        runVector("starve2", s, mkExp(0, 1, 0, 1, 1, 1, 0, 32'h5000, 4'hF, 0, 0, 1, 32'hC0DE0002));
        s.memRdata = 32'hC0DE0003;
        runVector("starve3", s, mkExp(1, 0, 0, 1, 1, 1, 0, 32'h200, 4'hF, 0, 0, 1, 32'hC0DE0003));
        s.memRdata = 32'hC0DE0004;
        runVector("starve4", s, mkExp(0, 1, 1, 0, 1, 1, 0, 32'h5000, 4'hF, 0, 1, 0, 32'hC0DE0004));
        runVector("starveDrain", mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5),
                  mkExp(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h5));
    endtask

    task automatic runLockHold();
        stim_t s;
        doReset();
        s = mkStim(0, 32'h300, 1, 0, 32'h4000, 0, 4'hF, 0, 0, 0);
        runVector("hold0", s, mkExp(0, 0, 0, 0, 1, 1, 0, 32'h4000, 4'hF, 0, 0, 0, 0));
        s.ifReq = 1;
        for (int i = 1; i < 4; i++)
            runVector($sformatf("hold%0d", i), s,
                      mkExp(0, 0, 0, 0, 1, 1, 0, 32'h4000, 4'hF, 0, 0, 0, 0));
        s.memGnt = 1;
        runVector("holdGnt", s, mkExp(0, 1, 0, 0, 1, 1, 0, 32'h4000, 4'hF, 0, 0, 0, 0));
        s = mkStim(1, 32'h300, 0, 0, 0, 0, 0, 0, 1, 32'h77);
        runVector("holdFetchWait", s, mkExp(0, 0, 0, 1, 1, 1, 0, 32'h300, 4'hF, 0, 0, 1, 32'h77));
        s = mkStim(1, 32'h300, 1, 1, 32'h4400, 32'h99, 4'h3, 0, 0, 0);
        runVector("holdFetchLocked", s, mkExp(0, 0, 0, 0, 1, 1, 0, 32'h300, 4'hF, 0, 0, 0, 0));
        s.memGnt = 1;
        runVector("holdFetchGnt", s, mkExp(1, 0, 0, 0, 1, 1, 0, 32'h300, 4'hF, 0, 0, 0, 0));
    endtask

    task automatic runResetMidAccess();
        doReset();
        runVector("rstIssue", mkStim(1, 32'h600, 0, 0, 0, 0, 0, 1, 0, 0),
                  mkExp(1, 0, 0, 0, 1, 0, 0, 32'h600, 4'hF, 0, 0, 0, 0));
        rst_i = 1'b1;
        runVector("rstDuring", mkStim(1, 32'h640, 0, 0, 0, 0, 0, 1, 0, 0), zeroExp());
        rst_i = 1'b0;
        runVector("rstLateResp", mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0), zeroExp());
        runVector("rstIdleIssue", mkStim(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0),
                  mkExp(1, 0, 0, 0, 1, 0, 0, 32'h700, 4'hF, 0, 0, 0, 0));
        runVector("rstDrain", mkStim(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h42),
                  mkExp(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h42));
    endtask

    // Reference model: one outstanding access in a queue, an integer streak,
    // and a remembered choice while the memory withholds acceptance.
    task automatic runRandom(input int cycles);
        access_t pendQ[$];
        int      streak = 0;
        bit      lockOn = 0;
        bit      lockFetch = 0;
        expect_t e;
        bit      issueOk;
        bit      pickFetch;
        doReset();
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!if_req_i && $urandom_range(0, 2) == 0) begin
                if_req_i  = 1'b1;
                if_addr_i = $urandom() & 32'hFFFF_FFFC;
            end
            if (!ls_req_i && $urandom_range(0, 2) == 0) begin
                ls_req_i   = 1'b1;
                ls_wr_en_i = 1'($urandom_range(0, 1));
                ls_addr_i  = $urandom();
                ls_wdata_i = $urandom();
                case ($urandom_range(0, 2))
                    0:       ls_byte_en_i = 4'b0001;
                    1:       ls_byte_en_i = 4'b0011;
                    default: ls_byte_en_i = 4'b1111;
                endcase
            end
            mem_gnt_i    = ($urandom_range(0, 2) != 0);
            mem_rvalid_i = (pendQ.size() != 0) ? 1'($urandom_range(0, 1))
                                               : ($urandom_range(0, 7) == 0);
            mem_rdata_i  = $urandom();
            #1;
            issueOk = (pendQ.size() == 0) || mem_rvalid_i;
            if (lockOn)                      pickFetch = lockFetch;
            else if (if_req_i && ls_req_i)   pickFetch = (streak >= LIMIT);
            else                             pickFetch = !ls_req_i;
            e = zeroExp();
            e.memReq = issueOk && (lockOn || if_req_i || ls_req_i);
            e.ifGnt  = e.memReq && mem_gnt_i && pickFetch;
            e.lsGnt  = e.memReq && mem_gnt_i && !pickFetch;
            if (pickFetch) begin
                e.memAddr = if_addr_i; e.memBe = 4'hF;
            end else begin
                e.memWr = ls_wr_en_i; e.memAddr = ls_addr_i;
                e.memBe = ls_byte_en_i; e.memWdata = ls_wdata_i;
            end
            if (pendQ.size() != 0 && mem_rvalid_i) begin
                e.ifRv      = pendQ[0].isFetch;
                e.lsRv      = !pendQ[0].isFetch;
                e.chkIfData = e.ifRv;
                e.chkLsData = e.lsRv && !pendQ[0].isWrite;
                e.rdata     = mem_rdata_i;
            end
            e.stall = (if_req_i && !e.ifGnt) || (ls_req_i && !e.lsGnt) ||
                      (pendQ.size() != 0 && !mem_rvalid_i);
            checkCycle("random", e);

            if (pendQ.size() != 0 && mem_rvalid_i) void'(pendQ.pop_front());
            if (e.ifGnt || e.lsGnt)
                pendQ.push_back('{isFetch: pickFetch, isWrite: !pickFetch && ls_wr_en_i});
            lockOn    = e.memReq && !mem_gnt_i;
            lockFetch = pickFetch;
            if (e.ifGnt || !if_req_i)      streak = 0;
            else if (e.lsGnt)              streak = (streak < LIMIT) ? streak + 1 : LIMIT;

            @(negedge clk_i);
            if (e.ifGnt) if_req_i = 1'b0;
            if (e.lsGnt) ls_req_i = 1'b0;
        end
        applyStimulus(quietStim());
    endtask

    initial begin
        @(negedge clk_i);
        doReset();
        runTable();
        runStarvation();
        runLockHold();
        runResetMidAccess();
        runRandom(1500);
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
